// File: rtl/rs_fifo_pkg.sv
// rs_fifo_pkg
//   Shared definitions for the TDP18K FIFO read-side logic.
//   - MODE_*        : 3-bit port width encodings of the FIFO primitive
//   - fwft_state_t  : occupancy state of the FWFT skid buffer
//   - clog2_depth() : pointer width for a buffer of a given depth (min 1 bit)
package rs_fifo_pkg;

    localparam logic [2:0] MODE_1  = 3'd0;
    localparam logic [2:0] MODE_2  = 3'd1;
    localparam logic [2:0] MODE_4  = 3'd2;
    localparam logic [2:0] MODE_9  = 3'd3;
    localparam logic [2:0] MODE_18 = 3'd4;

    typedef enum logic [1:0] {
        B_EMPTY = 2'd0,
        B_PART  = 2'd1,
        B_FULL  = 2'd2
    } fwft_state_t;

    function automatic int unsigned clog2_depth(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fwft_skid_buf.sv
// fwft_skid_buf
//   Circular register-array buffer holding words returned by the FIFO until
//   the downstream consumer accepts them. Head word is presented directly.
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   flush_i       : synchronous clear of pointers/level/state (contents kept)
//   push_i        : write push_data_i at the tail this edge
//   push_data_i   : word to store
//   pop_i         : consumer accepted the head word (ignored when empty)
//   valid_o       : buffer holds at least one word
//   data_o        : head word
//   level_o       : number of words held
module fwft_skid_buf
    import rs_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned SKID_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush_i,
    input  logic                            push_i,
    input  logic [DATA_WIDTH-1:0]           push_data_i,
    input  logic                            pop_i,
    output logic                            valid_o,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic [$clog2(SKID_DEPTH+1)-1:0] level_o
);

    localparam int unsigned PW = clog2_depth(SKID_DEPTH);
    localparam int unsigned LW = $clog2(SKID_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    fwft_state_t           state_q, state_d;
    logic                  pop_ok;

    assign pop_ok  = pop_i & (state_q != B_EMPTY);
    assign valid_o = (state_q != B_EMPTY);
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Datapath: storage, pointers and level
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d = (wr_ptr_q == PW'(SKID_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = (rd_ptr_q == PW'(SKID_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push_i, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Occupancy FSM
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = B_EMPTY;
        end else begin
            case (state_q)
                B_EMPTY: if (push_i) state_d = B_PART;
                B_PART: begin
                    if (push_i && !pop_ok && (level_q == LW'(SKID_DEPTH - 1)))
                        state_d = B_FULL;
                    else if (pop_ok && !push_i && (level_q == LW'(1)))
                        state_d = B_EMPTY;
                end
                B_FULL:  if (pop_ok && !push_i) state_d = B_PART;
                default: state_d = B_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= B_EMPTY;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
        end
    end

endmodule

// File: rtl/fifo_fwft_rd_adapter.sv
// fifo_fwft_rd_adapter
//   Read-side stage behind the TDP18K FIFO (FIFO mode). Issues FIFO reads on
//   credit so the skid buffer can never overflow, tracks reads in flight in a
//   RD_LATENCY-deep shift register and presents a first-word-fall-through
//   valid/ready stream. Sustains one word per clock with M_READY_i held high.
// Ports
//   CLK_i, RST_i      : clock, asynchronous active-high reset
//   FLUSH_i           : synchronous clear of buffer; in-flight returns dropped
//   FIFO_EMPTY_i      : FIFO EMPTY flag
//   FIFO_REN_o        : FIFO read enable
//   FIFO_RDATA_i      : FIFO read data, valid RD_LATENCY clocks after REN
//   FIFO_UNDERRUN_i   : FIFO UNDERRUN flag (error build only)
//   M_VALID_o/READY_i : output stream handshake, M_DATA_o output word
//   LEVEL_o           : words held in the skid buffer
//   ERR_o             : sticky error
// Configuration
//   FWFT_ERR_EN : when defined, ERR_o sets on FIFO_UNDERRUN_i or on a read
//                 issued while EMPTY; cleared by RST_i or FLUSH_i. Otherwise
//                 ERR_o is tied 0.
module fifo_fwft_rd_adapter
    import rs_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned SKID_DEPTH = 2
) (
    input  logic                            CLK_i,
    input  logic                            RST_i,
    input  logic                            FLUSH_i,
    input  logic                            FIFO_EMPTY_i,
    output logic                            FIFO_REN_o,
    input  logic [DATA_WIDTH-1:0]           FIFO_RDATA_i,
    input  logic                            FIFO_UNDERRUN_i,
    output logic                            M_VALID_o,
    input  logic                            M_READY_i,
    output logic [DATA_WIDTH-1:0]           M_DATA_o,
    output logic [$clog2(SKID_DEPTH+1)-1:0] LEVEL_o,
    output logic                            ERR_o
);

    if ((RD_LATENCY < 1) || (RD_LATENCY > 2)) begin : g_bad_latency
        $error("fifo_fwft_rd_adapter: RD_LATENCY must be 1 or 2");
    end
    if (SKID_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
        $error("fifo_fwft_rd_adapter: SKID_DEPTH must be >= RD_LATENCY+1");
    end

    logic [RD_LATENCY-1:0] inflight_q, inflight_d;
    logic [RD_LATENCY-1:0] discard_q, discard_d;
    logic [31:0]           inflight_cnt;
    logic [31:0]           occupancy;
    logic                  fifo_ren;
    logic                  pop;
    logic                  push;

    assign pop        = M_VALID_o & M_READY_i;
    assign push       = inflight_q[RD_LATENCY-1] & ~discard_q[RD_LATENCY-1];
    assign FIFO_REN_o = fifo_ren;

    // Credit check: words held plus words still coming back, less the word
    // leaving this cycle, must leave room. Reset also blocks issue so no read
    // escapes while the state is being cleared.
    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + 32'(inflight_q[i]);
        end
        occupancy = 32'(LEVEL_o) + inflight_cnt - 32'(pop);
        fifo_ren  = ~RST_i & ~FIFO_EMPTY_i & ~FLUSH_i & (occupancy < SKID_DEPTH);
    end

    // In-flight tracking. On flush the reads still travelling after this edge
    // are marked so their data is dropped on return instead of cancelled.
    always_comb begin
        inflight_d    = '0;
        discard_d     = '0;
        inflight_d[0] = fifo_ren;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            inflight_d[i] = inflight_q[i-1];
            discard_d[i]  = discard_q[i-1];
        end
        if (FLUSH_i) discard_d = inflight_d;
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fwft_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk         (CLK_i),
        .rst         (RST_i),
        .flush_i     (FLUSH_i),
        .push_i      (push),
        .push_data_i (FIFO_RDATA_i),
        .pop_i       (pop),
        .valid_o     (M_VALID_o),
        .data_o      (M_DATA_o),
        .level_o     (LEVEL_o)
    );

`ifdef FWFT_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | FIFO_UNDERRUN_i | (fifo_ren & FIFO_EMPTY_i);
        if (FLUSH_i) err_d = 1'b0;
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign ERR_o = err_q;
`else
    logic unused_underrun;
    assign unused_underrun = FIFO_UNDERRUN_i;
    assign ERR_o           = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_fwft_rd_adapter.sv
// tb_fifo_fwft_rd_adapter
//   Directed and randomized stimulus for fifo_fwft_rd_adapter. A FIFO model
//   supplies read data RD_LATENCY clocks after each read; a reference model
//   tracks the expected output queue, in-flight reads and the error flag.
//   Error expectations follow FWFT_ERR_EN.
module tb_fifo_fwft_rd_adapter;

    localparam int DW    = 18;
    localparam int LAT   = 1;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          flush;
    logic          fifo_empty;
    logic          fifo_ren;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_underrun;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [LW-1:0] level;
    logic          err;

    fifo_fwft_rd_adapter #(
        .DATA_WIDTH (DW),
        .RD_LATENCY (LAT),
        .SKID_DEPTH (DEPTH)
    ) u_dut (
        .CLK_i           (clk),
        .RST_i           (rst),
        .FLUSH_i         (flush),
        .FIFO_EMPTY_i    (fifo_empty),
        .FIFO_REN_o      (fifo_ren),
        .FIFO_RDATA_i    (fifo_rdata),
        .FIFO_UNDERRUN_i (fifo_underrun),
        .M_VALID_o       (m_valid),
        .M_READY_i       (m_ready),
        .M_DATA_o        (m_data),
        .LEVEL_o         (level),
        .ERR_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] w;
        int            arrive;
        bit            drop;
    } rd_t;

    logic [DW-1:0] src_q[$];   // FIFO contents not yet read
    rd_t           pend_q[$];  // reads issued, data not yet in the buffer
    logic [DW-1:0] exp_q[$];   // words expected in the skid buffer, head first
    bit            err_m;
    int            cyc, checks, failures, beats, gaps, last_beat, first_valid, t0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_q.delete();
        err_m = 1'b0;
    endtask

    task automatic start_test();
        beats       = 0;
        gaps        = 0;
        last_beat   = -10;
        first_valid = -1;
        t0          = cyc;
    endtask

    // One clock: inputs were set just after the falling edge; check outputs,
    // advance the model across the rising edge, then present FIFO read data.
    task automatic cycle();
        bit  pop;
        bit  exp_ren;
        int  occ;
        rd_t r;
        fifo_empty = (src_q.size() == 0);
        #1;
        pop     = (exp_q.size() > 0) && m_ready;
        occ     = exp_q.size() + pend_q.size() - (pop ? 1 : 0);
        exp_ren = !rst && (src_q.size() > 0) && !flush && (occ < DEPTH);
        chk("ren", fifo_ren, exp_ren);
        chk("valid", m_valid, exp_q.size() > 0);
        chk("level", level, exp_q.size());
        if (exp_q.size() > 0) chk("data", m_data, exp_q[0]);
`ifdef FWFT_ERR_EN
        chk("err", err, err_m);
`else
        chk("err", err, 0);
`endif
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (m_valid && m_ready) begin
            beats++;
            if (beats > 1 && last_beat != cyc - 1) gaps++;
            last_beat = cyc;
        end
        if (rst) begin
            model_reset();
        end else begin
            if (fifo_underrun) err_m = 1'b1;
            if (flush) err_m = 1'b0;
            if (pop) void'(exp_q.pop_front());
            if (pend_q.size() > 0 && pend_q[0].arrive == cyc) begin
                r = pend_q.pop_front();
                if (!r.drop && !flush) exp_q.push_back(r.w);
            end
            if (flush) begin
                exp_q.delete();
                foreach (pend_q[i]) pend_q[i].drop = 1'b1;
            end
            if (exp_ren) begin
                r.w      = src_q.pop_front();
                r.arrive = cyc + LAT;
                r.drop   = 1'b0;
                pend_q.push_back(r);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (pend_q.size() > 0 && pend_q[0].arrive == cyc) fifo_rdata = pend_q[0].w;
        else fifo_rdata = DW'($urandom);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        cyc           = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        m_ready       = 1'b0;
        fifo_underrun = 1'b0;
        fifo_empty    = 1'b1;
        fifo_rdata    = '0;
        start_test();

        // Reset state
        @(negedge clk);
        cycle();
        cycle();
        chk("rst_data", m_data, 0);
        rst = 1'b0;

        // Single word, latency
        start_test();
        src_q.push_back(18'h15566);
        m_ready = 1'b1;
        repeat (6) cycle();
        chk("t2_latency", first_valid - t0, LAT + 1);
        chk("t2_beats", beats, 1);

        // Streaming 64 words
        start_test();
        for (int unsigned i = 0; i < 64; i++) src_q.push_back(DW'(i));
        repeat (72) cycle();
        chk("t3_beats", beats, 64);
        chk("t3_gaps", gaps, 0);

        // Backpressure
        start_test();
        for (int unsigned i = 0; i < 10; i++) src_q.push_back(DW'(100 + i));
        m_ready = 1'b0;
        repeat (10) cycle();
        #1;
        chk("t4_level_sat", level, DEPTH);
        chk("t4_ren_off", fifo_ren, 0);
        chk("t4_head", m_data, 100);
        m_ready = 1'b1;
        repeat (20) cycle();
        chk("t4_drained", beats, 10);

        // Flush with a read in flight
        start_test();
        src_q.push_back(18'h00200);
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (4) cycle();
        chk("t5_no_beats", beats, 0);

        // Underrun pulse, sticky until flush
        fifo_underrun = 1'b1;
        cycle();
        fifo_underrun = 1'b0;
        repeat (3) cycle();
`ifdef FWFT_ERR_EN
        chk("t6_err_sticky", err, 1);
`else
        chk("t6_err_tied", err, 0);
`endif
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        chk("t6_err_clear", err, 0);

        // Reset mid-stream with the buffer full
        start_test();
        for (int unsigned i = 0; i < 6; i++) src_q.push_back(DW'(300 + i));
        m_ready = 1'b0;
        repeat (4) cycle();
        chk("t1_level_pre", level, 2);
        rst = 1'b1;
        model_reset();
        #1;
        chk("t1_ren", fifo_ren, 0);
        chk("t1_valid", m_valid, 0);
        chk("t1_data", m_data, 0);
        chk("t1_level", level, 0);
        chk("t1_err", err, 0);
        repeat (2) cycle();
        rst     = 1'b0;
        m_ready = 1'b1;
        repeat (10) cycle();

        // Randomized traffic
        repeat (400) begin
            m_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) src_q.push_back(DW'($urandom));
            end
            flush         = ($urandom_range(0, 31) == 0);
            fifo_underrun = ($urandom_range(0, 63) == 0);
            cycle();
        end
        flush         = 1'b0;
        fifo_underrun = 1'b0;
        m_ready       = 1'b1;
        repeat (20) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
